// File: rtl/boot_loader_if.sv
// ---------------------------------------------------------------------------
// boot_loader_if
//
// Serial boot-loader write port. A frame is shifted in MSB first on sdi while
// prog is high:
//   explicit frame : mode(0) | address[ADDR_W] | data[DATA_W]
//   auto frame     : mode(1) | data[DATA_W]     (address = previous + 1)
// The edge that samples the last data bit commits the write: wdata_o and
// address_o are updated and pwrite_o pulses for exactly one sclk cycle.
// Dropping prog mid-frame aborts the frame and raises the sticky err_o.
//
// Optional feature, enabled by defining BOOT_LOADER_PARITY_EN:
//   one extra bit after the data field; the ones count over mode, address
//   (explicit frames only), data and parity must be even. A parity failure
//   raises err_o and suppresses the write.
//
// Ports
//   sclk        in   single clock, rising edge
//   nrst        in   asynchronous active-low reset
//   prog        in   frame enable
//   sdi         in   serial frame data, MSB first
//   address_o   out  committed write address   [ADDR_W]
//   wdata_o     out  committed write data      [DATA_W]
//   pwrite_o    out  one-cycle write strobe
//   busy_o      out  high whenever the FSM is not IDLE
//   err_o       out  sticky frame-error flag
//   dbg_state_o out  FSM state (0 IDLE, 1 ADDR, 2 DATA, 3 PAR)
//
// Handshake: there is no back-pressure. Each rising sclk edge with prog high
// consumes exactly one sdi bit; pwrite_o is a strobe, valid for one cycle,
// and the consumer must accept it in that cycle.
// ---------------------------------------------------------------------------
module boot_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              sclk,
    input  logic              nrst,
    input  logic              prog,
    input  logic              sdi,
    output logic [ADDR_W-1:0] address_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              pwrite_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [1:0]        dbg_state_o
);

    // Longest field is 32 bits, so a 5-bit index covers every legal size.
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

`ifdef BOOT_LOADER_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_PAR  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;
`endif

    state_t             r_state;
    state_t             w_next;
    logic               r_mode;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]  r_addr_sh;
    logic [DATA_W-1:0]  r_data_sh;
`ifdef BOOT_LOADER_PARITY_EN
    logic               r_par;
`endif

    logic               w_start;
    logic               w_shift_a;
    logic               w_shift_d;
    logic               w_cnt_wrap;
    logic               w_commit;
    logic               w_fail;
    logic [ADDR_W:0]    w_addr_cat;
    logic [DATA_W:0]    w_data_cat;
    logic [ADDR_W-1:0]  w_addr_shift;
    logic [DATA_W-1:0]  w_data_shift;
    logic [DATA_W-1:0]  w_commit_data;

    // Shift-in values; the concatenation keeps DATA_W/ADDR_W = 1 legal.
    assign w_addr_cat   = {r_addr_sh, sdi};
    assign w_data_cat   = {r_data_sh, sdi};
    assign w_addr_shift = w_addr_cat[ADDR_W-1:0];
    assign w_data_shift = w_data_cat[DATA_W-1:0];

    // ---------------- state register ----------------
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next        = r_state;
        w_start       = 1'b0;
        w_shift_a     = 1'b0;
        w_shift_d     = 1'b0;
        w_cnt_wrap    = 1'b0;
        w_commit      = 1'b0;
        w_fail        = 1'b0;
        w_commit_data = w_data_shift;
        case (r_state)
            S_IDLE: begin
                if (prog) begin
                    w_start = 1'b1;
                    w_next  = sdi ? S_DATA : S_ADDR;
                end
            end
            S_ADDR: begin
                if (!prog) begin
                    w_fail = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_shift_a = 1'b1;
                    if (r_cnt == ADDR_LAST) begin
                        w_cnt_wrap = 1'b1;
                        w_next     = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (!prog) begin
                    w_fail = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_shift_d = 1'b1;
                    if (r_cnt == DATA_LAST) begin
                        w_cnt_wrap = 1'b1;
`ifdef BOOT_LOADER_PARITY_EN
                        w_next     = S_PAR;
`else
                        w_commit   = 1'b1;
                        w_next     = S_IDLE;
`endif
                    end
                end
            end
`ifdef BOOT_LOADER_PARITY_EN
            S_PAR: begin
                w_commit_data = r_data_sh;
                w_next        = S_IDLE;
                // Even parity: accumulated XOR plus the parity bit must be 0.
                if (!prog || (r_par ^ sdi)) begin
                    w_fail = 1'b1;
                end else begin
                    w_commit = 1'b1;
                end
            end
`endif
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        busy_o      = (r_state != S_IDLE);
        dbg_state_o = r_state;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            r_mode    <= 1'b0;
            r_cnt     <= '0;
            r_addr_sh <= '0;
            r_data_sh <= '0;
            address_o <= '0;
            wdata_o   <= '0;
            pwrite_o  <= 1'b0;
            err_o     <= 1'b0;
`ifdef BOOT_LOADER_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            pwrite_o <= w_commit;

            if (w_start) begin
                r_mode <= sdi;
                r_cnt  <= '0;
                err_o  <= 1'b0;
`ifdef BOOT_LOADER_PARITY_EN
                r_par  <= sdi;
`endif
            end

            if (w_shift_a || w_shift_d) begin
                r_cnt <= w_cnt_wrap ? '0 : r_cnt + CNT_W'(1);
`ifdef BOOT_LOADER_PARITY_EN
                r_par <= r_par ^ sdi;
`endif
            end
            if (w_shift_a) begin
                r_addr_sh <= w_addr_shift;
            end
            if (w_shift_d) begin
                r_data_sh <= w_data_shift;
            end

            if (w_commit) begin
                wdata_o   <= w_commit_data;
                // Auto frames post-increment the last committed address.
                address_o <= r_mode ? address_o + ADDR_W'(1) : r_addr_sh;
            end

            if (w_fail) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule
